peripheral_sqrt_if: RTL and testbench

//  Memory-mapped bus front end for the square-root accelerator on the femtoRV peripheral bus.

---
 rtl/peripheral_sqrt_if_pkg.sv | 33 +++
 rtl/peripheral_sqrt_if_if.sv | 18 +
 rtl/peripheral_sqrt_if_regs.sv | 139 +++++++++++++
 rtl/peripheral_sqrt_if.sv | 122 ++++++++++++
 tb/tb_peripheral_sqrt_if.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/peripheral_sqrt_if_pkg.sv
// Shared definitions for the sqrt peripheral: bus widths, register word offsets,
// STATUS bit layout and FSM state encodings.
// Optional feature macro used by this block: SQRT_IRQ_EN.
package peripheral_sqrt_if_pkg;

  localparam int unsigned BUS_AW = 5;
  localparam int unsigned BUS_DW = 32;

  // Register word offsets, decoded from addr[4:2]
  localparam logic [2:0] SQ_A      = 3'd0;
  localparam logic [2:0] SQ_CTRL   = 3'd1;
  localparam logic [2:0] SQ_RESULT = 3'd2;
  localparam logic [2:0] SQ_STATUS = 3'd3;
  localparam logic [2:0] SQ_IRQEN  = 3'd4;

  // STATUS bit indices
  localparam int unsigned ST_DONE = 0;
  localparam int unsigned ST_BUSY = 1;
  localparam int unsigned ST_ERR  = 2;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // STATUS register image, done in bit 0
  typedef struct packed {
    logic err;
    logic busy;
    logic done;
  } sq_status_t;

endpackage

// File: rtl/peripheral_sqrt_if_if.sv
// femtoRV peripheral bus bundle for the sqrt front end.
//   cs, addr, rd, wr, d_in : CPU side -> peripheral
//   d_out                  : registered read data back to the CPU
// Modports: master (CPU/bench), slave (peripheral).
interface peripheral_sqrt_if_if;
  import peripheral_sqrt_if_pkg::*;

  logic              cs;
  logic [BUS_AW-1:0] addr;
  logic              rd;
  logic              wr;
  logic [BUS_DW-1:0] d_in;
  logic [BUS_DW-1:0] d_out;

  modport master (output cs, addr, rd, wr, d_in, input d_out);
  modport slave  (input cs, addr, rd, wr, d_in, output d_out);

endinterface

// File: rtl/peripheral_sqrt_if_regs.sv
// Register file for the sqrt peripheral: address decode, A / RESULT / STATUS
// (and IRQ_EN when SQRT_IRQ_EN is defined) plus the registered read mux.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus             peripheral bus, slave side (drives d_out)
//   busy_i          FSM is in START or WAIT
//   start_ack_i     FSM accepted a start this cycle (clears done/err)
//   done_set_i      core answered in WAIT (load RESULT, set done)
//   err_set_i       watchdog expired (set err)
//   result_i        core result
//   a_o             current contents of register A
//   start_req_c     CTRL write with bit0=1 this cycle (combinational)
//   irq_o           level interrupt (SQRT_IRQ_EN only)
module peripheral_sqrt_if_regs
  import peripheral_sqrt_if_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  peripheral_sqrt_if_if.slave bus,
  input  logic               busy_i,
  input  logic               start_ack_i,
  input  logic               done_set_i,
  input  logic               err_set_i,
  input  logic [WIDTH/2-1:0] result_i,
  output logic [WIDTH-1:0]   a_o,
`ifdef SQRT_IRQ_EN
  output logic               irq_o,
`endif
  output logic               start_req_c
);

  localparam int unsigned RW = WIDTH / 2;

  logic             wr_c;
  logic             rd_c;
  logic [2:0]       idx_c;
  sq_status_t       status_c;

  logic [WIDTH-1:0]  a_q, a_d;
  logic [RW-1:0]     res_q, res_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [BUS_DW-1:0] d_out_q, d_out_d;
`ifdef SQRT_IRQ_EN
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
`endif

  // Byte lanes and upper data bits above WIDTH carry no meaning here
  logic unused_c;
  assign unused_c = ^{bus.d_in[BUS_DW-1:WIDTH], bus.addr[1:0]};

  assign wr_c        = bus.cs & bus.wr;
  assign rd_c        = bus.cs & bus.rd;
  assign idx_c       = bus.addr[4:2];
  assign start_req_c = wr_c && (idx_c == SQ_CTRL) && bus.d_in[0];

  // Next-state for registers; later assignments take priority, so a hardware
  // set beats a same-cycle software clear
  always_comb begin
    a_d      = a_q;
    res_d    = res_q;
    done_d   = done_q;
    err_d    = err_q;
    d_out_d  = d_out_q;
`ifdef SQRT_IRQ_EN
    irq_en_d = irq_en_q;
`endif
    status_c = '{err: err_q, busy: busy_i, done: done_q};

    if (wr_c && (idx_c == SQ_A)) a_d = bus.d_in[WIDTH-1:0];
`ifdef SQRT_IRQ_EN
    if (wr_c && (idx_c == SQ_IRQEN)) irq_en_d = bus.d_in[0];
`endif
    if (wr_c && (idx_c == SQ_STATUS)) begin
      if (bus.d_in[ST_DONE]) done_d = 1'b0;
      if (bus.d_in[ST_ERR])  err_d  = 1'b0;
    end
    if (start_ack_i) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (done_set_i) begin
      done_d = 1'b1;
      res_d  = result_i;
    end
    if (err_set_i) err_d = 1'b1;

    // Read data is captured only on a read; otherwise d_out holds
    if (rd_c) begin
      case (idx_c)
        SQ_A:      d_out_d = BUS_DW'(a_q);
        SQ_RESULT: d_out_d = BUS_DW'(res_q);
        SQ_STATUS: d_out_d = BUS_DW'(status_c);
`ifdef SQRT_IRQ_EN
        SQ_IRQEN:  d_out_d = BUS_DW'(irq_en_q);
`endif
        default:   d_out_d = '0;
      endcase
    end

`ifdef SQRT_IRQ_EN
    irq_d = irq_en_d & (done_d | err_d);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      d_out_q  <= '0;
`ifdef SQRT_IRQ_EN
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      a_q      <= a_d;
      res_q    <= res_d;
      done_q   <= done_d;
      err_q    <= err_d;
      d_out_q  <= d_out_d;
`ifdef SQRT_IRQ_EN
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`endif
    end
  end

  assign a_o       = a_q;
  assign bus.d_out = d_out_q;
`ifdef SQRT_IRQ_EN
  assign irq_o     = irq_q;
`endif

endmodule

// File: rtl/peripheral_sqrt_if.sv
// Bus front end for the square-root accelerator. Captures operand/start from
// CPU writes, drives the core's a/init inputs, catches the done pulse and
// holds result/status for reads. A watchdog aborts to idle if the core is silent.
// Optional feature macro: SQRT_IRQ_EN (adds irq port and IRQ_EN register).
// Ports:
//   clk, rst    clock, synchronous active-high reset (shared with the core)
//   bus         peripheral bus, slave side
//   sq_a        operand to core, frozen from start until the next start
//   sq_init     one-cycle start pulse to core
//   sq_result   core result, valid with sq_done
//   sq_done     one-cycle completion pulse from core
//   irq         level interrupt (SQRT_IRQ_EN only)
module peripheral_sqrt_if
  import peripheral_sqrt_if_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  peripheral_sqrt_if_if.slave bus,
  output logic [WIDTH-1:0]   sq_a,
  output logic               sq_init,
  input  logic [WIDTH/2-1:0] sq_result,
`ifdef SQRT_IRQ_EN
  output logic               irq,
`endif
  input  logic               sq_done
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [WIDTH-1:0]  sq_a_q, sq_a_d;
  logic              sq_init_q, sq_init_d;

  logic              busy_c;
  logic              start_req_c;
  logic              start_ack_c;
  logic              done_set_c;
  logic              err_set_c;
  logic [WIDTH-1:0]  a_c;

  assign busy_c = (state_q != ST_IDLE);

  peripheral_sqrt_if_regs #(
    .WIDTH (WIDTH)
  ) u_regs (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy_i      (busy_c),
    .start_ack_i (start_ack_c),
    .done_set_i  (done_set_c),
    .err_set_i   (err_set_c),
    .result_i    (sq_result),
    .a_o         (a_c),
`ifdef SQRT_IRQ_EN
    .irq_o       (irq),
`endif
    .start_req_c (start_req_c)
  );

  // Control FSM with watchdog; sq_done is only honoured in WAIT and wins
  // over a same-cycle timeout
  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    sq_a_d      = sq_a_q;
    start_ack_c = 1'b0;
    done_set_c  = 1'b0;
    err_set_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_req_c) begin
          state_d     = ST_START;
          sq_a_d      = a_c;
          start_ack_c = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        wdog_d  = '0;
      end
      ST_WAIT: begin
        if (sq_done) begin
          done_set_c = 1'b1;
          state_d    = ST_IDLE;
        end else if (wdog_q == WDOG_W'(TIMEOUT)) begin
          err_set_c = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered pulse that is high exactly while the FSM sits in START
    sq_init_d = (state_d == ST_START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wdog_q    <= '0;
      sq_a_q    <= '0;
      sq_init_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      sq_a_q    <= sq_a_d;
      sq_init_q <= sq_init_d;
    end
  end

  assign sq_a    = sq_a_q;
  assign sq_init = sq_init_q;

endmodule

// File: tb/tb_peripheral_sqrt_if.sv
// Self-checking bench for peripheral_sqrt_if with a behavioural sqrt core
// model (random latency) and an integer-sqrt reference computed arithmetically.
module tb_peripheral_sqrt_if;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned TIMEOUT = 15;

  localparam logic [4:0] A_ADR   = 5'h00;
  localparam logic [4:0] CTL_ADR = 5'h04;
  localparam logic [4:0] RES_ADR = 5'h08;
  localparam logic [4:0] STA_ADR = 5'h0C;
  localparam logic [4:0] IEN_ADR = 5'h10;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   sq_a;
  logic               sq_init;
  logic [WIDTH/2-1:0] sq_result;
  logic               sq_done;
`ifdef SQRT_IRQ_EN
  logic               irq;
`endif

  peripheral_sqrt_if_if bus_if ();

  peripheral_sqrt_if #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .sq_a      (sq_a),
    .sq_init   (sq_init),
    .sq_result (sq_result),
`ifdef SQRT_IRQ_EN
    .irq       (irq),
`endif
    .sq_done   (sq_done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Core model state
  logic               model_done   = 1'b0;
  logic [WIDTH/2-1:0] model_result = '0;
  logic               manual_done  = 1'b0;
  logic               core_en      = 1'b1;
  int                 core_lat     = 3;
  logic               core_busy    = 1'b0;
  int                 core_cnt     = 0;
  logic [WIDTH-1:0]   core_a       = '0;
  int                 init_cnt     = 0;
  int                 init_double  = 0;
  logic               prev_init    = 1'b0;
  logic               init_s, rst_s;
  logic [WIDTH-1:0]   a_s;

  assign sq_done   = model_done | manual_done;
  assign sq_result = manual_done ? 8'hAB : model_result;

  function automatic int unsigned isqrt(input int unsigned x);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Behavioural sqrt core: latches sq_a on sq_init, answers core_lat cycles later
  always @(posedge clk) begin
    init_s = sq_init;
    a_s    = sq_a;
    rst_s  = rst;
    #1;
    model_done = 1'b0;
    if (rst_s) begin
      core_busy = 1'b0;
      prev_init = 1'b0;
    end else begin
      if (init_s && prev_init) init_double++;
      prev_init = init_s;
      if (init_s) begin
        init_cnt++;
        core_busy = 1'b1;
        core_cnt  = core_lat;
        core_a    = a_s;
      end else if (core_busy) begin
        if (core_cnt > 0) core_cnt--;
        if (core_cnt == 0 && core_en) begin
          model_done   = 1'b1;
          model_result = (WIDTH/2)'(isqrt(32'(core_a)));
          core_busy    = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] adr, input logic [31:0] data);
    @(posedge clk); #1;
    bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.addr = adr; bus_if.d_in = data;
    @(posedge clk); #1;
    bus_if.cs = 1'b0; bus_if.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] adr, output logic [31:0] data);
    @(posedge clk); #1;
    bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = adr;
    @(posedge clk); #1;
    bus_if.cs = 1'b0; bus_if.rd = 1'b0;
    data = bus_if.d_out;
  endtask

  task automatic wait_idle(output logic ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus_read(STA_ADR, s);
      if (s[1] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Full operation: load A, start, check the init pulse, then status and result
  task automatic run_op(input logic [15:0] a, input int lat, input string tag);
    logic [31:0] d;
    logic        ok;
    core_lat = lat;
    bus_write(A_ADR, 32'(a));
    bus_write(CTL_ADR, 32'h1);
    @(negedge clk);
    chk({tag, ".init_hi"}, 32'(sq_init), 32'h1);
    chk({tag, ".sq_a"}, 32'(sq_a), 32'(a));
    @(negedge clk);
    chk({tag, ".init_lo"}, 32'(sq_init), 32'h0);
    wait_idle(ok);
    chk({tag, ".idle"}, 32'(ok), 32'h1);
    bus_read(STA_ADR, d);
    chk({tag, ".status"}, d, 32'h1);
    bus_read(RES_ADR, d);
    chk({tag, ".result"}, d, isqrt(32'(a)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] d;
    logic        ok;
    int          n0;
    logic [15:0] ra;

    rst = 1'b1;
    bus_if.cs = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    bus_if.addr = '0; bus_if.d_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst.d_out", bus_if.d_out, 32'h0);
    chk("rst.sq_a", 32'(sq_a), 32'h0);
    chk("rst.sq_init", 32'(sq_init), 32'h0);
`ifdef SQRT_IRQ_EN
    chk("rst.irq", 32'(irq), 32'h0);
`endif
    bus_read(STA_ADR, d); chk("rst.status", d, 32'h0);
    bus_read(RES_ADR, d); chk("rst.result", d, 32'h0);
    bus_read(A_ADR, d);   chk("rst.a", d, 32'h0);

    // A is WIDTH bits, zero-extended on read; CTRL and unmapped read as 0
    bus_write(A_ADR, 32'hDEAD_1234);
    bus_read(A_ADR, d);   chk("a.mask", d, 32'h1234);
    bus_read(CTL_ADR, d); chk("ctrl.rd", d, 32'h0);
    bus_read(5'h14, d);   chk("unmapped.rd", d, 32'h0);
    bus_write(5'h18, 32'hFFFF_FFFF);
    bus_read(A_ADR, d);   chk("unmapped.wr", d, 32'h1234);

    // Basic operation and boundary operands
    run_op(16'd144, 3, "op144");
    run_op(16'd0, 1, "op0");
    run_op(16'hFFFF, 5, "opFFFF");
    bus_write(STA_ADR, 32'h1);
    bus_read(STA_ADR, d); chk("clr.done", d, 32'h0);

    // Random operands and core latencies
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom_range(0, 65535));
      run_op(ra, int'($urandom_range(1, 12)), "rand");
    end

    // Start and A write while busy
    core_lat = 12;
    n0 = init_cnt;
    bus_write(A_ADR, 32'd144);
    bus_write(CTL_ADR, 32'h1);
    bus_write(CTL_ADR, 32'h1);
    bus_write(A_ADR, 32'd9);
    bus_read(STA_ADR, d); chk("busy.status", d, 32'h2);
    chk("busy.sq_a", 32'(sq_a), 32'd144);
    bus_read(A_ADR, d);   chk("busy.a", d, 32'd9);
    wait_idle(ok);        chk("busy.idle", 32'(ok), 32'h1);
    chk("busy.init_cnt", 32'(init_cnt - n0), 32'h1);
    bus_read(RES_ADR, d); chk("busy.result", d, 32'd12);
    core_lat = 2;
    bus_write(CTL_ADR, 32'h1);
    wait_idle(ok);        chk("restart.idle", 32'(ok), 32'h1);
    chk("restart.sq_a", 32'(sq_a), 32'd9);
    bus_read(RES_ADR, d); chk("restart.result", d, 32'd3);

    // Watchdog timeout: core never answers
    core_en = 1'b0;
    bus_write(A_ADR, 32'd100);
    bus_write(CTL_ADR, 32'h1);
    repeat (10) @(posedge clk);
    bus_read(STA_ADR, d); chk("tmo.busy", d, 32'h2);
    repeat (8) @(posedge clk);
    bus_read(STA_ADR, d); chk("tmo.err", d, 32'h4);
    bus_read(RES_ADR, d); chk("tmo.result", d, 32'd3);
    bus_write(STA_ADR, 32'h4);
    bus_read(STA_ADR, d); chk("tmo.clr", d, 32'h0);

    // Core answer and STATUS clear in the same cycle: done stays set
    bus_write(A_ADR, 32'd25);
    bus_write(CTL_ADR, 32'h1);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.addr = STA_ADR; bus_if.d_in = 32'h1;
    manual_done = 1'b1;
    @(posedge clk); #1;
    bus_if.cs = 1'b0; bus_if.wr = 1'b0;
    manual_done = 1'b0;
    bus_read(STA_ADR, d); chk("race.status", d, 32'h1);
    bus_read(RES_ADR, d); chk("race.result", d, 32'hAB);

    // sq_done outside WAIT is ignored
    bus_write(STA_ADR, 32'h1);
    @(posedge clk); #1 manual_done = 1'b1;
    @(posedge clk); #1 manual_done = 1'b0;
    bus_read(STA_ADR, d); chk("idle_done.status", d, 32'h0);

    // Reset during WAIT, then a late core answer
    bus_write(A_ADR, 32'd64);
    bus_write(CTL_ADR, 32'h1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n0 = init_cnt;
    manual_done = 1'b1;
    @(posedge clk); #1 manual_done = 1'b0;
    @(negedge clk);
    chk("rstw.sq_init", 32'(sq_init), 32'h0);
    chk("rstw.sq_a", 32'(sq_a), 32'h0);
    bus_read(STA_ADR, d); chk("rstw.status", d, 32'h0);
    bus_read(RES_ADR, d); chk("rstw.result", d, 32'h0);
    chk("rstw.init_cnt", 32'(init_cnt - n0), 32'h0);
    core_en = 1'b1;

`ifdef SQRT_IRQ_EN
    bus_write(IEN_ADR, 32'h1);
    bus_read(IEN_ADR, d); chk("irq.en_rd", d, 32'h1);
    chk("irq.low", 32'(irq), 32'h0);
    run_op(16'd49, 4, "irq49");
    chk("irq.high", 32'(irq), 32'h1);
    bus_write(STA_ADR, 32'h1);
    @(negedge clk);
    chk("irq.drop", 32'(irq), 32'h0);
`else
    bus_write(IEN_ADR, 32'h1);
    bus_read(IEN_ADR, d); chk("noirq.unmapped", d, 32'h0);
`endif

    chk("init.one_cycle", 32'(init_double), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
